// File: rtl/fir_filter_mc.sv
// fir_filter_mc: multi-channel signed FIR filter.
// Each channel keeps its own sample history in a wide synchronous-read RAM with LANES taps per word.
// All channels share one coefficient RAM. One word is processed per clock using LANES multipliers,
// a registered adder tree and an accumulator. The output is rounded half-up and saturated.
// After reset, a clear pass zeroes every history word and every coefficient.
module fir_filter_mc #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int LANES        = 8,
  parameter int WORDS        = 16,
  parameter int CHANNELS     = 4,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_SHIFT    = 15,
  localparam int TAPS        = LANES * WORDS,
  localparam int ACC_WIDTH   = SAMPLE_WIDTH + COEF_WIDTH + $clog2(TAPS),
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W       = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                        clkIn,
  input  logic                        nResetIn,
  input  logic                        startIn,
  input  logic [CH_W-1:0]             channelIn,
  input  logic signed [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                        coefWrIn,
  input  logic [TAP_W-1:0]            coefAddrIn,
  input  logic signed [COEF_WIDTH-1:0] coefDataIn,
  output logic                        busyOut,
  output logic                        doneOut,
  output logic [CH_W-1:0]             channelOut,
  output logic signed [ACC_WIDTH-1:0] accOut,
  output logic signed [OUT_WIDTH-1:0] dataOut,
  output logic                        satOut
);

  localparam int DEPTH   = WORDS * CHANNELS;
  localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int HADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W  = SAMPLE_WIDTH + COEF_WIDTH;
  localparam int HWORD_W = LANES * SAMPLE_WIDTH;
  localparam int CWORD_W = LANES * COEF_WIDTH;

  localparam logic [HADDR_W-1:0] CLR_LAST   = HADDR_W'(DEPTH - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS - 1);
  localparam logic [CH_W:0]      CH_LIMIT   = (CH_W + 1)'(CHANNELS);
  localparam logic [TAP_W:0]     TAP_LIMIT  = (TAP_W + 1)'(TAPS);
  localparam logic signed [ACC_WIDTH:0] ROUND_ADD = {{ACC_WIDTH{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX_W =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN_W = ~OUT_MAX_W;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // control state
  state_t                       r_state;
  logic [HADDR_W-1:0]           r_clrCnt;
  logic [WORD_W-1:0]            r_word;
  logic                         r_drainCnt;
  logic [CH_W-1:0]              r_chan;
  logic signed [SAMPLE_WIDTH-1:0] r_carry;
  logic                         r_busy;
  logic                         r_done;
  logic [CH_W-1:0]              r_chanOut;
  logic signed [ACC_WIDTH-1:0]  r_accOut;
  logic signed [OUT_WIDTH-1:0]  r_dataOut;
  logic                         r_satOut;

  // memories and their read registers
  logic [HWORD_W-1:0]           r_histMem [DEPTH];
  logic [HWORD_W-1:0]           r_histRd;
  logic [CWORD_W-1:0]           r_coefMem [WORDS];
  logic [CWORD_W-1:0]           r_coefRd;

  // datapath pipeline
  logic signed [PROD_W-1:0]     r_prod [LANES];
  logic                         r_prodVld;
  logic signed [ACC_WIDTH-1:0]  r_tree;
  logic                         r_treeVld;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  // combinational helpers
  logic                         w_accept;
  logic                         w_coefWr;
  logic [WORD_W-1:0]            w_rdWord;
  logic [HADDR_W-1:0]           w_histRdAddr;
  logic                         w_histWe;
  logic [HADDR_W-1:0]           w_histWrAddr;
  logic [HWORD_W-1:0]           w_histWrData;
  logic [HWORD_W-1:0]           w_shift;
  logic [LANES-1:0]             w_coefWe;
  logic [WORD_W-1:0]            w_coefWrWord;
  logic signed [COEF_WIDTH-1:0] w_coefWrData;
  logic signed [ACC_WIDTH-1:0]  w_treeSum;
  logic signed [ACC_WIDTH:0]    w_rounded;
  logic signed [ACC_WIDTH:0]    w_scaled;
  logic signed [OUT_WIDTH-1:0]  w_outData;
  logic                         w_outSat;

  // History word address of a given channel and word index.
  function automatic logic [HADDR_W-1:0] hist_addr(input logic [CH_W-1:0] ch,
                                                   input logic [WORD_W-1:0] wd);
    return HADDR_W'(int'(ch) * WORDS + int'(wd));
  endfunction

  // Request qualification: only IDLE accepts work, and only for existing channels/taps.
  always_comb begin
    w_accept = 1'b0;
    w_coefWr = 1'b0;
    if (r_state == S_IDLE) begin
      w_accept = startIn && ({1'b0, channelIn} < CH_LIMIT);
      w_coefWr = coefWrIn && ({1'b0, coefAddrIn} < TAP_LIMIT);
    end else begin
      w_accept = 1'b0;
      w_coefWr = 1'b0;
    end
  end

  // Read word select: word 0 in FETCH, the next word while running (wraps harmlessly at the end).
  always_comb begin
    w_rdWord = '0;
    case (r_state)
      S_FETCH: w_rdWord = '0;
      S_RUN:   w_rdWord = (r_word == WORD_LAST) ? '0 : r_word + 1'b1;
      default: w_rdWord = '0;
    endcase
    w_histRdAddr = hist_addr(r_chan, w_rdWord);
  end

  // Shifted history word: the carried-in sample enters lane 0, the top lane leaves as next carry.
  always_comb begin
    w_shift = '0;
    w_shift[SAMPLE_WIDTH-1:0] = r_carry;
    for (int l = 1; l < LANES; l++) begin
      w_shift[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_histRd[(l-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // History write port: zero fill while clearing, shifted write-back while running.
  always_comb begin
    w_histWe     = 1'b0;
    w_histWrAddr = '0;
    w_histWrData = '0;
    case (r_state)
      S_CLEAR: begin
        w_histWe     = 1'b1;
        w_histWrAddr = r_clrCnt;
        w_histWrData = '0;
      end
      S_RUN: begin
        w_histWe     = 1'b1;
        w_histWrAddr = hist_addr(r_chan, r_word);
        w_histWrData = w_shift;
      end
      default: begin
        w_histWe     = 1'b0;
        w_histWrAddr = '0;
        w_histWrData = '0;
      end
    endcase
  end

  // Coefficient write port: whole word zeroed while clearing, single lane on a host write.
  always_comb begin
    w_coefWe     = '0;
    w_coefWrWord = '0;
    w_coefWrData = '0;
    if (r_state == S_CLEAR) begin
      w_coefWe     = '1;
      w_coefWrWord = WORD_W'(int'(r_clrCnt) % WORDS);
      w_coefWrData = '0;
    end else if (w_coefWr) begin
      w_coefWe     = LANES'(1) << (int'(coefAddrIn) % LANES);
      w_coefWrWord = WORD_W'(int'(coefAddrIn) / LANES);
      w_coefWrData = coefDataIn;
    end else begin
      w_coefWe     = '0;
      w_coefWrWord = '0;
      w_coefWrData = '0;
    end
  end

  // History RAM: one write port, one registered read port.
  always_ff @(posedge clkIn) begin
    if (w_histWe) begin
      r_histMem[w_histWrAddr] <= w_histWrData;
    end
    r_histRd <= r_histMem[w_histRdAddr];
  end

  // Coefficient RAM: per-lane write enables, one registered word-wide read port.
  always_ff @(posedge clkIn) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_coefWe[l]) begin
        r_coefMem[w_coefWrWord][l*COEF_WIDTH +: COEF_WIDTH] <= w_coefWrData;
      end
    end
    r_coefRd <= r_coefMem[w_rdWord];
  end

  // Adder tree input: sign-extended sum of all lane products.
  always_comb begin
    w_treeSum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_treeSum = w_treeSum + ACC_WIDTH'(r_prod[l]);
    end
  end

  // Round half-up, scale down and saturate the accumulator for the narrow output.
  always_comb begin
    w_rounded = ACC_WIDTH'(0) + ROUND_ADD;
    w_rounded = (ACC_WIDTH + 1)'(r_acc) + ROUND_ADD;
    w_scaled  = w_rounded >>> OUT_SHIFT;
    if (w_scaled > OUT_MAX_W) begin
      w_outData = OUT_MAX;
      w_outSat  = 1'b1;
    end else if (w_scaled < OUT_MIN_W) begin
      w_outData = OUT_MIN;
      w_outSat  = 1'b1;
    end else begin
      w_outData = w_scaled[OUT_WIDTH-1:0];
      w_outSat  = 1'b0;
    end
  end

  // MAC pipeline: lane products, registered tree sum, accumulator cleared at the start of each run.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      for (int l = 0; l < LANES; l++) begin
        r_prod[l] <= '0;
      end
      r_prodVld <= 1'b0;
      r_tree    <= '0;
      r_treeVld <= 1'b0;
      r_acc     <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_prod[l] <= $signed(w_shift[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]) *
                     $signed(r_coefRd[l*COEF_WIDTH +: COEF_WIDTH]);
      end
      r_prodVld <= (r_state == S_RUN);
      r_tree    <= w_treeSum;
      r_treeVld <= r_prodVld;
      if (r_state == S_FETCH) begin
        r_acc <= '0;
      end else if (r_treeVld) begin
        r_acc <= r_acc + r_tree;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      r_state    <= S_CLEAR;
      r_clrCnt   <= '0;
      r_word     <= '0;
      r_drainCnt <= 1'b0;
      r_chan     <= '0;
      r_carry    <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_chanOut  <= '0;
      r_accOut   <= '0;
      r_dataOut  <= '0;
      r_satOut   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_clrCnt == CLR_LAST) begin
            r_clrCnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_clrCnt <= r_clrCnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_chan  <= channelIn;
            r_carry <= dataIn;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_word  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_carry <= r_histRd[(LANES-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          if (r_word == WORD_LAST) begin
            r_drainCnt <= 1'b0;
            r_state    <= S_DRAIN;
          end else begin
            r_word <= r_word + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drainCnt) begin
            r_state <= S_DONE;
          end else begin
            r_drainCnt <= 1'b1;
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_chanOut <= r_chan;
          r_accOut  <= r_acc;
          r_dataOut <= w_outData;
          r_satOut  <= w_outSat;
          r_state   <= S_IDLE;
        end
        default: begin
          r_clrCnt <= '0;
          r_busy   <= 1'b1;
          r_state  <= S_CLEAR;
        end
      endcase
    end
  end

  assign busyOut    = r_busy;
  assign doneOut    = r_done;
  assign channelOut = r_chanOut;
  assign accOut     = r_accOut;
  assign dataOut    = r_dataOut;
  assign satOut     = r_satOut;

endmodule
